// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives a 1-cycle-latency instruction memory and feeds decode through a 2-entry buffer.
// Optional FETCH_CTRL_PERF_EN adds saturating perf_fetched / perf_stall counters.
module fetch_ctrl #(
    parameter logic [3:0] HALT_OP  = 4'hF,
    parameter logic [4:0] RESET_PC = 5'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        redirect,
    input  logic [4:0]  redirect_addr,
    output logic        imem_rd_en,
    output logic [4:0]  imem_addr,
    input  logic [12:0] imem_data,
    output logic [12:0] ir_out,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic        halted
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [15:0] perf_fetched,
    output logic [15:0] perf_stall
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALT} state_t;

    state_t      state_reg, state_next;
    logic [4:0]  pc_reg;
    logic [1:0]  count_reg;
    logic        inflight_reg;
    logic        kill_reg;
    logic        head_reg, tail_reg;
    logic [12:0] ibuf_reg [2];

    logic        pop, push, halt_seen;
    logic [2:0]  occupancy;

    assign pop       = ir_valid && ir_ready;
    assign push      = inflight_reg && !kill_reg && !redirect;
    assign halt_seen = push && (state_reg == RUN) && (imem_data[12:9] == HALT_OP);
    assign occupancy = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};

    assign imem_addr = pc_reg;
    assign ir_valid  = (count_reg != 2'd0);
    assign ir_out    = ibuf_reg[head_reg];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (!redirect && start) state_next = RUN;
            RUN:   if (!redirect && halt_seen) state_next = DRAIN;
            // Once in DRAIN nothing more is pushed, so the last entry left is the halt.
            DRAIN: begin
                if (redirect)                           state_next = RUN;
                else if (pop && (count_reg == 2'd1))    state_next = HALT;
            end
            HALT:  if (redirect || start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        imem_rd_en = (state_reg == RUN) && !redirect && (occupancy < 3'd2);
        halted     = (state_reg == HALT);
    end

    // On halt capture the PC is held so that a restart resumes right after the halt,
    // even though the read issued alongside the capture is killed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_reg       <= RESET_PC;
            inflight_reg <= 1'b0;
            kill_reg     <= 1'b0;
            count_reg    <= 2'd0;
            head_reg     <= 1'b0;
            tail_reg     <= 1'b0;
            for (int i = 0; i < 2; i++) ibuf_reg[i] <= 13'd0;
        end else begin
            inflight_reg <= imem_rd_en;
            kill_reg     <= redirect || halt_seen;
            if (redirect)        pc_reg <= redirect_addr;
            else if (halt_seen)  pc_reg <= pc_reg;
            else if (imem_rd_en) pc_reg <= pc_reg + 5'd1;

            if (redirect) begin
                count_reg <= 2'd0;
                head_reg  <= 1'b0;
                tail_reg  <= 1'b0;
            end else begin
                count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
                if (push) begin
                    ibuf_reg[tail_reg] <= imem_data;
                    tail_reg           <= ~tail_reg;
                end
                if (pop) head_reg <= ~head_reg;
            end
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched <= 16'd0;
            perf_stall   <= 16'd0;
        end else begin
            if (pop && (perf_fetched != 16'hFFFF))
                perf_fetched <= perf_fetched + 16'd1;
            if (ir_valid && !ir_ready && (perf_stall != 16'hFFFF))
                perf_stall <= perf_stall + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: models the 1-cycle synchronous instruction memory and checks cycle-exact behaviour.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        redirect = 1'b0;
    logic [4:0]  redirect_addr = 5'd0;
    logic        imem_rd_en;
    logic [4:0]  imem_addr;
    logic [12:0] imem_data = 13'd0;
    logic [12:0] ir_out;
    logic        ir_valid;
    logic        ir_ready = 1'b0;
    logic        halted;
`ifdef FETCH_CTRL_PERF_EN
    logic [15:0] perf_fetched;
    logic [15:0] perf_stall;
`endif

    logic [12:0] mem [32];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (imem_rd_en) imem_data <= mem[imem_addr];

    fetch_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .redirect(redirect),
        .redirect_addr(redirect_addr), .imem_rd_en(imem_rd_en), .imem_addr(imem_addr),
        .imem_data(imem_data), .ir_out(ir_out), .ir_valid(ir_valid),
        .ir_ready(ir_ready), .halted(halted)
`ifdef FETCH_CTRL_PERF_EN
        , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic init_mem;
        for (int i = 0; i < 32; i++) mem[i] = 13'(i + 1);
    endtask

    task automatic do_reset;
        reset = 1'b0; start = 1'b0; redirect = 1'b0; redirect_addr = 5'd0; ir_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Pulses start with ir_ready high; the following tick is cycle n=1 (first rd_en).
    task automatic kick;
        ir_ready = 1'b1;
        tick();
        start = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        @(negedge clk);
        checks++; if (imem_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %0b want 0", imem_rd_en); end
        checks++; if (imem_addr !== 5'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", imem_addr); end
        checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", ir_valid); end
        checks++; if (ir_out !== 13'd0) begin errors++; $display("FAIL reset_ir_out got %h want 0", ir_out); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %0b want 0", halted); end
        tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        checks++; if (imem_rd_en !== 1'b0) begin errors++; $display("FAIL idle_rd_en got %0b want 0", imem_rd_en); end
        $display("test_reset done");
    endtask

    task automatic test_fetch;
        init_mem(); do_reset(); kick();
        checks++; if (imem_rd_en !== 1'b0) begin errors++; $display("FAIL fetch_start_rd_en got %0b want 0", imem_rd_en); end
        for (int n = 1; n <= 6; n++) begin
            tick(); start = 1'b0;
            @(negedge clk);
            if (n <= 4) begin
                checks++; if (imem_rd_en !== 1'b1 || imem_addr !== 5'(n - 1)) begin
                    errors++; $display("FAIL fetch_addr n=%0d got en=%0b addr=%0d want en=1 addr=%0d", n, imem_rd_en, imem_addr, n - 1); end
            end
            if (n <= 2) begin
                checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL fetch_early_valid n=%0d got %0b want 0", n, ir_valid); end
            end else begin
                checks++; if (ir_valid !== 1'b1 || ir_out !== 13'(n - 2)) begin
                    errors++; $display("FAIL fetch_ir n=%0d got v=%0b ir=%h want v=1 ir=%h", n, ir_valid, ir_out, 13'(n - 2)); end
            end
        end
        $display("test_fetch done");
    endtask

    task automatic test_backpressure;
        init_mem(); do_reset(); kick();
        for (int n = 1; n <= 12; n++) begin
            tick(); start = 1'b0;
            if (n == 4) ir_ready = 1'b0;
            if (n == 9) ir_ready = 1'b1;
            @(negedge clk);
            if (n >= 4 && n <= 8) begin
                checks++; if (imem_rd_en !== 1'b0 || ir_valid !== 1'b1 || ir_out !== 13'd2) begin
                    errors++; $display("FAIL bp_hold n=%0d got en=%0b v=%0b ir=%h want en=0 v=1 ir=0002", n, imem_rd_en, ir_valid, ir_out); end
            end
            if (n >= 9) begin
                checks++; if (ir_valid !== 1'b1 || ir_out !== 13'(n - 7)) begin
                    errors++; $display("FAIL bp_resume_ir n=%0d got v=%0b ir=%h want v=1 ir=%h", n, ir_valid, ir_out, 13'(n - 7)); end
            end
            if (n >= 9 && n <= 11) begin
                checks++; if (imem_rd_en !== 1'b1 || imem_addr !== 5'(n - 6)) begin
                    errors++; $display("FAIL bp_resume_addr n=%0d got en=%0b addr=%0d want en=1 addr=%0d", n, imem_rd_en, imem_addr, n - 6); end
            end
        end
        $display("test_backpressure done");
    endtask

    task automatic test_redirect;
        init_mem(); do_reset(); kick();
        for (int n = 1; n <= 11; n++) begin
            tick(); start = 1'b0;
            if (n == 4)  ir_ready = 1'b0;
            if (n == 6)  begin redirect = 1'b1; redirect_addr = 5'd20; end
            if (n == 7)  redirect = 1'b0;
            if (n == 10) ir_ready = 1'b1;
            @(negedge clk);
            case (n)
                6: begin checks++; if (imem_rd_en !== 1'b0) begin errors++; $display("FAIL redir_same_cycle got en=%0b want 0", imem_rd_en); end end
                7: begin checks++; if (imem_rd_en !== 1'b1 || imem_addr !== 5'd20 || ir_valid !== 1'b0) begin
                       errors++; $display("FAIL redir_first got en=%0b addr=%0d v=%0b want en=1 addr=20 v=0", imem_rd_en, imem_addr, ir_valid); end end
                8: begin checks++; if (imem_rd_en !== 1'b1 || imem_addr !== 5'd21 || ir_valid !== 1'b0) begin
                       errors++; $display("FAIL redir_second got en=%0b addr=%0d v=%0b want en=1 addr=21 v=0", imem_rd_en, imem_addr, ir_valid); end end
                9, 10: begin checks++; if (ir_valid !== 1'b1 || ir_out !== 13'd21) begin
                       errors++; $display("FAIL redir_ir n=%0d got v=%0b ir=%h want v=1 ir=0015", n, ir_valid, ir_out); end end
                11: begin checks++; if (ir_valid !== 1'b1 || ir_out !== 13'd22) begin
                       errors++; $display("FAIL redir_next got v=%0b ir=%h want v=1 ir=0016", ir_valid, ir_out); end end
                default: ;
            endcase
        end
        $display("test_redirect done");
    endtask

    task automatic test_halt;
        init_mem(); mem[3] = 13'h1E00; do_reset(); kick();
        for (int n = 1; n <= 12; n++) begin
            tick(); start = (n == 9);
            @(negedge clk);
            case (n)
                6: begin checks++; if (ir_valid !== 1'b1 || ir_out !== 13'h1E00 || halted !== 1'b0 || imem_rd_en !== 1'b0) begin
                       errors++; $display("FAIL halt_pop got v=%0b ir=%h h=%0b en=%0b want v=1 ir=1e00 h=0 en=0", ir_valid, ir_out, halted, imem_rd_en); end end
                7, 8: begin checks++; if (halted !== 1'b1 || ir_valid !== 1'b0 || imem_rd_en !== 1'b0) begin
                       errors++; $display("FAIL halt_state n=%0d got h=%0b v=%0b en=%0b want h=1 v=0 en=0", n, halted, ir_valid, imem_rd_en); end end
                10: begin checks++; if (halted !== 1'b0 || imem_rd_en !== 1'b1 || imem_addr !== 5'd4) begin
                       errors++; $display("FAIL halt_restart got h=%0b en=%0b addr=%0d want h=0 en=1 addr=4", halted, imem_rd_en, imem_addr); end end
                12: begin checks++; if (ir_valid !== 1'b1 || ir_out !== 13'd5) begin
                       errors++; $display("FAIL halt_resume_ir got v=%0b ir=%h want v=1 ir=0005", ir_valid, ir_out); end end
                default: ;
            endcase
        end
        $display("test_halt done");
    endtask

    task automatic test_wrap;
        init_mem(); do_reset();
        tick(); redirect = 1'b1; redirect_addr = 5'd31;
        tick(); redirect = 1'b0;
        @(negedge clk);
        checks++; if (imem_addr !== 5'd31 || imem_rd_en !== 1'b0 || halted !== 1'b0) begin
            errors++; $display("FAIL idle_redirect got addr=%0d en=%0b h=%0b want addr=31 en=0 h=0", imem_addr, imem_rd_en, halted); end
        kick();
        for (int n = 1; n <= 4; n++) begin
            tick(); start = 1'b0;
            @(negedge clk);
            if (n <= 3) begin
                checks++; if (imem_rd_en !== 1'b1 || imem_addr !== 5'((n + 30) % 32)) begin
                    errors++; $display("FAIL wrap_addr n=%0d got en=%0b addr=%0d want en=1 addr=%0d", n, imem_rd_en, imem_addr, (n + 30) % 32); end
            end
            if (n == 3) begin checks++; if (ir_out !== 13'd32) begin errors++; $display("FAIL wrap_ir31 got %h want 0020", ir_out); end end
            if (n == 4) begin checks++; if (ir_out !== 13'd1) begin errors++; $display("FAIL wrap_ir0 got %h want 0001", ir_out); end end
        end
        $display("test_wrap done");
    endtask

    task automatic test_async_reset;
        init_mem(); do_reset(); kick();
        for (int n = 1; n <= 4; n++) begin
            tick(); start = 1'b0;
        end
        @(negedge clk);
        checks++; if (ir_valid !== 1'b1 || imem_rd_en !== 1'b1) begin
            errors++; $display("FAIL areset_pre got v=%0b en=%0b want v=1 en=1", ir_valid, imem_rd_en); end
        #1 reset = 1'b0;
        #1;
        checks++; if (ir_valid !== 1'b0 || imem_rd_en !== 1'b0 || halted !== 1'b0) begin
            errors++; $display("FAIL areset_drop got v=%0b en=%0b h=%0b want 0 0 0", ir_valid, imem_rd_en, halted); end
        checks++; if (imem_addr !== 5'd0 || ir_out !== 13'd0) begin
            errors++; $display("FAIL areset_pc got addr=%0d ir=%h want addr=0 ir=0000", imem_addr, ir_out); end
        tick(); reset = 1'b1;
        @(negedge clk);
        checks++; if (imem_rd_en !== 1'b0 || ir_valid !== 1'b0) begin
            errors++; $display("FAIL areset_idle got en=%0b v=%0b want 0 0", imem_rd_en, ir_valid); end
        $display("test_async_reset done");
    endtask

    initial begin
        init_mem();
        test_reset();
        test_fetch();
        test_backpressure();
        test_redirect();
        test_halt();
        test_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
